// File: rtl/x_delay_line_ctrl.sv
// x_delay_line_ctrl: measurement sequencer for the x_delay_line TDC.
// Optional macro X_DLC_BUBBLE_FIX_EN: majority-of-3 bubble fix before popcount.
module x_delay_line_ctrl #(
  parameter  int WIDTH   = 32,
  parameter  int SETTLE  = 4,
  parameter  int AVG_MAX = 7,
  localparam int CW      = $clog2(WIDTH + 1),
  localparam int SW      = CW + AVG_MAX
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic [2:0]       i_avg_log2,
  output logic             o_busy,
  output logic             o_dl_start,
  input  logic [WIDTH-1:0] i_dl_data,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [SW-1:0]    o_res_sum,
  output logic [CW-1:0]    o_res_mean,
  output logic             o_res_sat
);

  localparam int RW  = (AVG_MAX > 0) ? AVG_MAX : 1;
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [2:0] NMAX = 3'((AVG_MAX > 7) ? 7 : AVG_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       n_q, n_d;
  logic [SW-1:0]    acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [SCW-1:0]   wcnt_q, wcnt_d;
  logic             start_q, start_d;
  logic [2:0]       n_in;
  logic [WIDTH-1:0] word_fix;
  logic [CW-1:0]    tap_cnt;
  logic             word_ones;

  assign n_in = (i_avg_log2 > NMAX) ? NMAX : i_avg_log2;

  // Tap count of the sampled word, optionally bubble-corrected first
  always_comb begin
`ifdef X_DLC_BUBBLE_FIX_EN
    logic [WIDTH+1:0] ext;
    ext = {1'b0, i_dl_data, 1'b1};
    for (int i = 0; i < WIDTH; i++) begin
      word_fix[i] = (ext[i] & ext[i+1]) |
                    (ext[i] & ext[i+2]) |
                    (ext[i+1] & ext[i+2]);
    end
`else
    word_fix = i_dl_data;
`endif
    tap_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tap_cnt = tap_cnt + CW'(word_fix[i]);
    end
    word_ones = &i_dl_data;
  end

  // State and datapath registers; reset aborts any campaign
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      start_q <= start_d;
    end
  end

  // Next-state sequencing of the launch/settle/sample loop
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_go) state_d = S_FIRE;
      S_FIRE:   state_d = S_WAIT;
      S_WAIT:   if (wcnt_q == '0) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (rem_q == '0) ? S_DONE : S_FIRE;
      S_DONE:   if (i_res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters and accumulator updates per state
  always_comb begin
    n_d    = n_q;
    acc_d  = acc_q;
    sat_d  = sat_q;
    rem_d  = rem_q;
    wcnt_d = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_go) begin
          n_d   = n_in;
          acc_d = '0;
          sat_d = 1'b0;
          rem_d = RW'((1 << n_in) - 1);
        end
      end
      S_FIRE: wcnt_d = SCW'(SETTLE - 1);
      S_WAIT: begin
        if (wcnt_q != '0) wcnt_d = wcnt_q - SCW'(1);
      end
      S_SAMPLE: begin
        acc_d = acc_q + SW'(tap_cnt);
        sat_d = sat_q | word_ones;
        if (rem_q != '0) rem_d = rem_q - RW'(1);
      end
      default: ;
    endcase
  end

  // Outputs; launch pulse is registered off the next state
  always_comb begin
    start_d     = (state_d == S_FIRE);
    o_dl_start  = start_q;
    o_busy      = (state_q != S_IDLE);
    o_res_valid = (state_q == S_DONE);
    o_res_sum   = acc_q;
    o_res_mean  = CW'(acc_q >> n_q);
    o_res_sat   = sat_q;
  end

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
// tb_x_delay_line_ctrl: randomized self-checking bench for x_delay_line_ctrl.
// Reference model computes taps, timing and results from plain arithmetic.
module tb_x_delay_line_ctrl;

  localparam int WIDTH   = 32;
  localparam int SETTLE  = 4;
  localparam int AVG_MAX = 7;
  localparam int CW      = 6;
  localparam int SW      = 13;
  localparam int PER     = SETTLE + 2;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_go = 1'b0;
  logic [2:0]        i_avg_log2 = '0;
  logic [WIDTH-1:0]  i_dl_data = '0;
  logic              i_res_ready = 1'b0;
  logic              o_busy;
  logic              o_dl_start;
  logic              o_res_valid;
  logic [SW-1:0]     o_res_sum;
  logic [CW-1:0]     o_res_mean;
  logic              o_res_sat;

  int errs = 0;
  int checks = 0;
  logic [31:0] wbuf [128];
  int exp_sum;
  int exp_mean;
  int exp_sat;

  x_delay_line_ctrl #(
    .WIDTH(WIDTH),
    .SETTLE(SETTLE),
    .AVG_MAX(AVG_MAX)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_go(i_go),
    .i_avg_log2(i_avg_log2),
    .o_busy(o_busy),
    .o_dl_start(o_dl_start),
    .i_dl_data(i_dl_data),
    .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_res_sum(o_res_sum),
    .o_res_mean(o_res_mean),
    .o_res_sat(o_res_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_taps(input logic [31:0] w);
    int ones;
    ones = 0;
`ifdef X_DLC_BUBBLE_FIX_EN
    begin
      int b [0:33];
      b[0]  = 1;
      b[33] = 0;
      for (int i = 0; i < 32; i++) b[i+1] = int'(w[i]);
      for (int i = 0; i < 32; i++)
        if (b[i] + b[i+1] + b[i+2] >= 2) ones++;
    end
`else
    for (int i = 0; i < 32; i++) ones += int'(w[i]);
`endif
    return ones;
  endfunction

  function automatic logic [31:0] therm(input int k);
    if (k >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << k) - 32'd1;
  endfunction

  task automatic run(input string tag, input int n_req);
    int nn, ns, pulses, vcyc, lim;
    int pcyc [128];
    nn = (n_req > AVG_MAX) ? AVG_MAX : n_req;
    ns = 1 << nn;
    exp_sum = 0;
    exp_sat = 0;
    for (int k = 0; k < ns; k++) begin
      exp_sum += model_taps(wbuf[k]);
      if (wbuf[k] == 32'hFFFF_FFFF) exp_sat = 1;
    end
    exp_mean = exp_sum / ns;
    @(negedge i_clk);
    i_go = 1'b1;
    i_avg_log2 = 3'(n_req);
    i_res_ready = 1'b0;
    pulses = 0;
    vcyc = -1;
    for (int c = 1; c <= ns * PER + 20; c++) begin
      @(negedge i_clk);
      if (o_dl_start) begin
        if (pulses < 128) begin
          pcyc[pulses] = c;
          i_dl_data = wbuf[pulses];
        end
        pulses++;
      end
      if (o_res_valid) begin
        vcyc = c;
        break;
      end
      i_go = 1'($urandom_range(0, 1));
      i_res_ready = (c < ns * PER) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check({tag, ":valid_cycle"}, longint'(vcyc), longint'(ns * PER + 1));
    check({tag, ":pulses"}, longint'(pulses), longint'(ns));
    lim = (pulses < ns) ? pulses : ns;
    for (int k = 0; k < lim; k++)
      check({tag, ":pulse_cycle"}, longint'(pcyc[k]), longint'(k * PER + 1));
    check({tag, ":sum"}, longint'(o_res_sum), longint'(exp_sum));
    check({tag, ":mean"}, longint'(o_res_mean), longint'(exp_mean));
    check({tag, ":sat"}, longint'(o_res_sat), longint'(exp_sat));
    check({tag, ":busy"}, longint'(o_busy), 1);
  endtask

  task automatic accept(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      i_go = 1'($urandom_range(0, 1));
      i_res_ready = 1'b0;
      @(negedge i_clk);
      check({tag, ":hold_valid"}, longint'(o_res_valid), 1);
      check({tag, ":hold_start"}, longint'(o_dl_start), 0);
      check({tag, ":hold_sum"}, longint'(o_res_sum), longint'(exp_sum));
      check({tag, ":hold_mean"}, longint'(o_res_mean), longint'(exp_mean));
      check({tag, ":hold_sat"}, longint'(o_res_sat), longint'(exp_sat));
    end
    i_go = 1'b1;
    i_res_ready = 1'b1;
    @(negedge i_clk);
    check({tag, ":acc_valid"}, longint'(o_res_valid), 0);
    check({tag, ":acc_busy"}, longint'(o_busy), 0);
    i_go = 1'b0;
    i_res_ready = 1'b0;
    @(negedge i_clk);
    check({tag, ":idle_busy"}, longint'(o_busy), 0);
    check({tag, ":idle_start"}, longint'(o_dl_start), 0);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    check("rst:busy", longint'(o_busy), 0);
    check("rst:start", longint'(o_dl_start), 0);
    check("rst:valid", longint'(o_res_valid), 0);
    check("rst:sum", longint'(o_res_sum), 0);
    check("rst:mean", longint'(o_res_mean), 0);
    check("rst:sat", longint'(o_res_sat), 0);
    i_rst = 1'b0;

    @(negedge i_clk);
    i_go = 1'b1;
    i_avg_log2 = 3'd3;
    @(negedge i_clk);
    i_go = 1'b0;
    check("abort:fire", longint'(o_dl_start), 1);
    @(negedge i_clk);
    @(negedge i_clk);
    check("abort:wait_busy", longint'(o_busy), 1);
    #2 i_rst = 1'b1;
    #1;
    check("abort:busy", longint'(o_busy), 0);
    check("abort:start", longint'(o_dl_start), 0);
    check("abort:valid", longint'(o_res_valid), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("abort:idle_busy", longint'(o_busy), 0);
      check("abort:idle_start", longint'(o_dl_start), 0);
      check("abort:idle_valid", longint'(o_res_valid), 0);
    end

    wbuf[0] = 32'h0000_00FF;
    run("single", 0);
    check("single:sum_lit", longint'(o_res_sum), 8);
    check("single:mean_lit", longint'(o_res_mean), 8);
    accept("single", 10);

    wbuf[0] = 32'h0F;
    wbuf[1] = 32'h1F;
    wbuf[2] = 32'h3F;
    wbuf[3] = 32'h7F;
    run("avg", 2);
    check("avg:sum_lit", longint'(o_res_sum), 22);
    check("avg:mean_lit", longint'(o_res_mean), 5);
    accept("avg", 0);

    for (int k = 0; k < 128; k++) wbuf[k] = 32'hFFFF_FFFF;
    run("sat", 7);
    check("sat:sum_lit", longint'(o_res_sum), 4096);
    check("sat:mean_lit", longint'(o_res_mean), 32);
    check("sat:sat_lit", longint'(o_res_sat), 1);
    accept("sat", 1);

    wbuf[0] = 32'h0000_00F7;
    run("bubble", 0);
`ifdef X_DLC_BUBBLE_FIX_EN
    check("bubble:sum_lit", longint'(o_res_sum), 8);
`else
    check("bubble:sum_lit", longint'(o_res_sum), 7);
`endif
    accept("bubble", 2);

    for (int t = 0; t < 20; t++) begin
      int n;
      n = int'($urandom_range(0, 4));
      for (int k = 0; k < (1 << n); k++) begin
        case ($urandom_range(0, 3))
          0: wbuf[k] = therm(int'($urandom_range(0, 32)));
          1: wbuf[k] = 32'hFFFF_FFFF;
          2: wbuf[k] = $urandom;
          default: begin
            logic [31:0] w;
            w = therm(int'($urandom_range(2, 31)));
            w[$urandom_range(0, 31)] ^= 1'b1;
            wbuf[k] = w;
          end
        endcase
      end
      run("rand", n);
      accept("rand", int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
